// File: rtl/alu_seq.sv
// alu_seq: sequencer that drives an external ALU, repeating an op cmd_rep+1 times into acc.
// Define ALU_SEQ_FLAGS_EN to enable the flag_z/flag_n status outputs.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_rep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] b_q;
  logic [2:0] op_q;
  logic [3:0] cnt;
  logic xfer;
  assign xfer = cmd_valid & cmd_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (xfer ? (cmd_load ? DONE : EXEC) : IDLE)
             : state == EXEC ? (cnt == 4'd0 ? DONE : EXEC)
             : IDLE;
  always_comb begin
    cmd_ready = state == IDLE;
    busy      = state != IDLE;
    done      = state == DONE;
    alu_a     = acc;
    alu_b     = state == EXEC ? b_q : '0;
    alu_sel   = state == EXEC ? op_q : 3'd0;
  end
  // xfer can only happen in IDLE, so it never collides with the EXEC update
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc  <= '0;
      b_q  <= '0;
      op_q <= '0;
      cnt  <= '0;
    end else if (xfer) begin
      if (cmd_load) acc <= cmd_data;
      else begin
        op_q <= cmd_op;
        b_q  <= cmd_data;
        cnt  <= cmd_rep;
      end
    end else if (state == EXEC) begin
      acc <= alu_result;
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
`ifdef ALU_SEQ_FLAGS_EN
  assign flag_z = acc == '0;
  assign flag_n = acc[WIDTH-1];
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural external ALU.
module tb_alu_seq;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic [3:0] cmd_rep = 4'd0;
  logic [W-1:0] alu_a, alu_b, alu_result, acc;
  logic [2:0] alu_sel;
  logic busy, done, flag_z, flag_n;
  typedef struct {logic [W-1:0] acc; int lat;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] m_acc = '0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rep(cmd_rep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .acc(acc), .busy(busy), .done(done), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    case (s)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return a - 1'b1;
      3'd5: return a + b;
      3'd6: return a - b;
      default: return a + 1'b1;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  task automatic send(input logic ld, input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] rep, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d; cmd_rep = rep;
    if (ld) begin e.acc = d; e.lat = 1; end
    else begin
      e.acc = m_acc;
      for (int i = 0; i <= int'(rep); i++) e.acc = alu_f(e.acc, d, op);
      e.lat = int'(rep) + 2;
    end
    m_acc = e.acc;
    sb.push_back(e);
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_before_xfer: got %b want 1", cmd_ready); end
  endtask

  task automatic wait_done(input bit hold);
    exp_t e;
    int k;
    bit seen;
    logic ez, en;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; cmd_valid = 1'b0; break; end
      if (hold) begin
        cmd_data = W'($urandom); cmd_op = 3'($urandom); cmd_rep = 4'($urandom); cmd_load = 1'($urandom);
        n_chk++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_while_busy: got %b want 0", cmd_ready); end
      end else cmd_valid = 1'b0;
    end
    e = sb.pop_front();
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL done_timeout: no done within 40 cycles, want latency %0d", e.lat); return; end
    n_chk++;
    if (k != e.lat) begin n_fail++; $display("FAIL done_latency: got %0d want %0d", k, e.lat); end
    n_chk++;
    if (acc !== e.acc) begin n_fail++; $display("FAIL acc_result: got %h want %h", acc, e.acc); end
`ifdef ALU_SEQ_FLAGS_EN
    ez = e.acc == '0; en = e.acc[W-1];
`else
    ez = 1'b0; en = 1'b0;
`endif
    n_chk++;
    if (flag_z !== ez || flag_n !== en) begin n_fail++; $display("FAIL flags: got z=%b n=%b want z=%b n=%b", flag_z, flag_n, ez, en); end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL done_pulse_end: got done=%b ready=%b want 0 1", done, cmd_ready); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (acc !== '0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_state: got acc=%h busy=%b done=%b want 0 0 0", acc, busy, done); end
    n_chk++;
    if (cmd_ready !== 1'b1 || alu_b !== '0 || alu_sel !== 3'd0) begin n_fail++; $display("FAIL reset_idle_outputs: got ready=%b b=%h sel=%0d want 1 0 0", cmd_ready, alu_b, alu_sel); end
    rst = 1'b0;
  endtask

  task automatic test_inc();
    send(1'b1, 3'd0, 16'h00FF, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd7, 16'h0000, 4'd2, 1'b0); wait_done(1'b0);
    n_chk++;
    if (acc !== 16'h0102) begin n_fail++; $display("FAIL inc_rep2: got %h want 0102", acc); end
  endtask

  task automatic test_wrap();
    send(1'b1, 3'd0, 16'hFFFF, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd7, 16'h0000, 4'd0, 1'b0); wait_done(1'b0);
    n_chk++;
    if (acc !== 16'h0000) begin n_fail++; $display("FAIL wrap_inc: got %h want 0000", acc); end
  endtask

  task automatic test_sub();
    send(1'b1, 3'd0, 16'h0005, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd6, 16'h0007, 4'd0, 1'b0); wait_done(1'b0);
    n_chk++;
    if (acc !== 16'hFFFE) begin n_fail++; $display("FAIL sub_neg: got %h want fffe", acc); end
  endtask

  task automatic test_logic();
    send(1'b1, 3'd0, 16'h0F0F, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd0, 16'h1234, 4'd0, 1'b0); wait_done(1'b0);
    n_chk++;
    if (acc !== 16'hF0F0) begin n_fail++; $display("FAIL not_op: got %h want f0f0", acc); end
    send(1'b0, 3'd3, 16'hFFFF, 4'd0, 1'b0); wait_done(1'b0);
    n_chk++;
    if (acc !== 16'h0F0F) begin n_fail++; $display("FAIL xor_op: got %h want 0f0f", acc); end
    send(1'b0, 3'd1, 16'h00FF, 4'd1, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd2, 16'hA000, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd4, 16'h0000, 4'd3, 1'b0); wait_done(1'b0);
  endtask

  task automatic test_rep15();
    send(1'b1, 3'd0, 16'h0000, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd5, 16'h0003, 4'd15, 1'b0); wait_done(1'b0);
  endtask

  task automatic test_abort();
    bit spur;
    send(1'b1, 3'd0, 16'h0000, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd5, 16'h0001, 4'd15, 1'b0);
    void'(sb.pop_back());
    for (int k = 1; k <= 5; k++) begin @(negedge clk); cmd_valid = 1'b0; end
    n_chk++;
    if (busy !== 1'b1 || acc !== 16'h0004) begin n_fail++; $display("FAIL abort_pre: got busy=%b acc=%h want 1 0004", busy, acc); end
    rst = 1'b1;
    #1;
    n_chk++;
    if (acc !== '0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_async: got acc=%h busy=%b done=%b want 0 0 0", acc, busy, done); end
    m_acc = '0;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    send(1'b1, 3'd0, 16'h1234, 4'd0, 1'b1); wait_done(1'b0);
    spur = 1'b0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (done !== 1'b0) spur = 1'b1; end
    n_chk++;
    if (spur) begin n_fail++; $display("FAIL abort_no_done: got done pulse want none"); end
  endtask

  task automatic test_back_to_back();
    send(1'b1, 3'd0, 16'h0003, 4'd0, 1'b0); wait_done(1'b0);
    send(1'b0, 3'd5, 16'h0002, 4'd3, 1'b0); wait_done(1'b1);
    n_chk++;
    if (acc !== 16'h000B) begin n_fail++; $display("FAIL hold_single_cmd: got %h want 000b", acc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      send(1'($urandom), 3'($urandom), W'($urandom), 4'($urandom_range(0, 5)), 1'b0);
      wait_done(1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_sub();
    test_logic();
    test_rep15();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
